// File: rtl/iir_coef_sequencer_if.sv
// Host-side bus of iir_coef_sequencer: shadow-bank writes, commit request and status.
interface iir_coef_sequencer_if;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        commit;
    logic        busy;
    logic        wr_err;

    modport master (
        output wr, addr, wdata, commit,
        input  busy, wr_err
    );

    modport slave (
        input  wr, addr, wdata, commit,
        output busy, wr_err
    );
endinterface

// File: rtl/iir_coef_sequencer.sv
// Clock-enable generator and atomic shadow->active coefficient bank for the stereo IIR filter.
// Optional: define IIR_SEQ_FLUSH_EN to build the post-commit flush pulse.
module iir_coef_sequencer #(
    parameter int unsigned CE_DIV  = 256,
    parameter bit          STEREO  = 1'b1,
    parameter logic [39:0] DEF_CX  = 40'h0,
    parameter logic [23:0] DEF_CXS = 24'h0,
    parameter logic [23:0] DEF_CY0 = 24'h0,
    parameter logic [23:0] DEF_CY1 = 24'h0,
    parameter logic [23:0] DEF_CY2 = 24'h0
) (
    input  logic        clk,
    input  logic        reset,
    iir_coef_sequencer_if.slave bus,
    output logic        ce,
    output logic        sample_ce,
    output logic        flush,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2
);

    localparam logic [15:0] CntLast = 16'(CE_DIV - 1);

    typedef enum logic {StIdle, StPending} state_e;

    logic [15:0] cnt_q;
    logic        cnt_wrap;
    logic        phase_q;
    logic        ce_q;
    logic        sample_ce_q;

    state_e      state_q;
    logic        busy_q;
    logic        wr_err_q;
    logic        addr_ok;
    logic        wr_ok;
    logic        apply;

    logic [39:0] sh_cx_q;
    logic [23:0] sh_cxs_q;
    logic [23:0] sh_cy0_q;
    logic [23:0] sh_cy1_q;
    logic [23:0] sh_cy2_q;

    logic [39:0] act_cx_q;
    logic [23:0] act_cxs_q;
    logic [23:0] act_cy0_q;
    logic [23:0] act_cy1_q;
    logic [23:0] act_cy2_q;

    assign cnt_wrap = (cnt_q == CntLast);
    assign addr_ok  = (bus.addr <= 4'd5);
    assign wr_ok    = bus.wr && !busy_q && addr_ok;
    assign apply    = (state_q == StPending) && sample_ce_q;

    // Divider and stereo phase; ce/sample_ce are registered one cycle after the wrap count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            ce_q        <= 1'b0;
            sample_ce_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_wrap ? '0 : cnt_q + 16'd1;
            ce_q        <= cnt_wrap;
            sample_ce_q <= cnt_wrap && (phase_q || !STEREO);
            if (cnt_wrap) begin
                phase_q <= ~phase_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_cx_q  <= DEF_CX;
            sh_cxs_q <= DEF_CXS;
            sh_cy0_q <= DEF_CY0;
            sh_cy1_q <= DEF_CY1;
            sh_cy2_q <= DEF_CY2;
            wr_err_q <= 1'b0;
        end else begin
            if (bus.wr && (busy_q || !addr_ok)) begin
                wr_err_q <= 1'b1;
            end
            if (wr_ok) begin
                case (bus.addr)
                    4'd0:    sh_cx_q[31:0]  <= bus.wdata;
                    4'd1:    sh_cx_q[39:32] <= bus.wdata[7:0];
                    4'd2:    sh_cxs_q       <= bus.wdata[23:0];
                    4'd3:    sh_cy0_q       <= bus.wdata[23:0];
                    4'd4:    sh_cy1_q       <= bus.wdata[23:0];
                    4'd5:    sh_cy2_q       <= bus.wdata[23:0];
                    default: ;
                endcase
            end
        end
    end

    // Commit FSM: the whole bank moves on one edge, right after a sample_ce cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            act_cx_q  <= DEF_CX;
            act_cxs_q <= DEF_CXS;
            act_cy0_q <= DEF_CY0;
            act_cy1_q <= DEF_CY1;
            act_cy2_q <= DEF_CY2;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.commit) begin
                        state_q <= StPending;
                        busy_q  <= 1'b1;
                    end
                end
                StPending: begin
                    if (apply) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        act_cx_q  <= sh_cx_q;
                        act_cxs_q <= sh_cxs_q;
                        act_cy0_q <= sh_cy0_q;
                        act_cy1_q <= sh_cy1_q;
                        act_cy2_q <= sh_cy2_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IIR_SEQ_FLUSH_EN
    logic flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= apply;
        end
    end

    assign flush = flush_q;
`else
    assign flush = 1'b0;
`endif

    assign ce         = ce_q;
    assign sample_ce  = sample_ce_q;
    assign bus.busy   = busy_q;
    assign bus.wr_err = wr_err_q;
    assign cx         = act_cx_q;
    assign cx0        = act_cxs_q[7:0];
    assign cx1        = act_cxs_q[15:8];
    assign cx2        = act_cxs_q[23:16];
    assign cy0        = act_cy0_q;
    assign cy1        = act_cy1_q;
    assign cy2        = act_cy2_q;

endmodule

// File: tb/tb_iir_coef_sequencer.sv
// Self-checking bench for iir_coef_sequencer: write/commit table plus hand-written corner sequences.
module tb_iir_coef_sequencer;

    localparam int unsigned CeDiv  = 4;
    localparam logic [39:0] DefCx  = 40'h01_0000_0002;
    localparam logic [23:0] DefCxs = 24'h030201;
    localparam logic [23:0] DefCy0 = 24'h200000;
    localparam logic [23:0] DefCy1 = 24'h100000;
    localparam logic [23:0] DefCy2 = 24'h080000;

    typedef struct packed {
        logic [39:0] cx;
        logic [23:0] cxs;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } bank_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        bit          commit;
        bit          exp_err;
        bank_t       exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        sample_ce;
    logic        flush;
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;

    iir_coef_sequencer_if bus ();

    iir_coef_sequencer #(
        .CE_DIV  (CeDiv),
        .STEREO  (1'b1),
        .DEF_CX  (DefCx),
        .DEF_CXS (DefCxs),
        .DEF_CY0 (DefCy0),
        .DEF_CY1 (DefCy1),
        .DEF_CY2 (DefCy2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ce        (ce),
        .sample_ce (sample_ce),
        .flush     (flush),
        .cx        (cx),
        .cx0       (cx0),
        .cx1       (cx1),
        .cx2       (cx2),
        .cy0       (cy0),
        .cy1       (cy1),
        .cy2       (cy2)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    torn    = 0;
    int    stray   = 0;
    bank_t sb[$];
    bank_t exp_active;
    vec_t  tbl[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bank_t mk_bank(input logic [39:0] bcx, input logic [23:0] bcxs,
                                      input logic [23:0] b0, input logic [23:0] b1,
                                      input logic [23:0] b2);
        bank_t b;
        b.cx  = bcx;
        b.cxs = bcxs;
        b.cy0 = b0;
        b.cy1 = b1;
        b.cy2 = b2;
        return b;
    endfunction

    function automatic vec_t mk_vec(input logic [3:0] a, input logic [31:0] d, input bit c,
                                    input bit e, input bank_t b);
        vec_t v;
        v.addr    = a;
        v.wdata   = d;
        v.commit  = c;
        v.exp_err = e;
        v.exp     = b;
        return v;
    endfunction

    function automatic bank_t dut_bank();
        return mk_bank(cx, {cx2, cx1, cx0}, cy0, cy1, cy2);
    endfunction

    // All drive tasks start and end at posedge+1.
    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk); #1;
        bus.wr    = 1'b0;
    endtask

    task automatic commit_pulse();
        bus.commit = 1'b1;
        @(posedge clk); #1;
        bus.commit = 1'b0;
        check("busy_after_commit", bus.busy, 1);
    endtask

    task automatic wait_applied();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("apply_done_in_time", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    // Scoreboard side: an apply is busy falling; compare the popped bank and flush there.
    initial begin
        bit    prev_busy = 1'b0;
        bit    prev_sce  = 1'b0;
        bit    apply_now;
        bank_t cur;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                prev_sce  = 1'b0;
            end else begin
                apply_now = prev_busy && !bus.busy;
                cur = dut_bank();
                if (prev_busy && prev_sce) check("apply_at_first_sample_ce", bus.busy, 0);
                if (apply_now) begin
                    check("apply_after_sample_ce", prev_sce, 1);
                    check("apply_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) exp_active = sb.pop_front();
                    check("apply_cx", cur.cx, exp_active.cx);
                    check("apply_cxs", cur.cxs, exp_active.cxs);
                    check("apply_cy0", cur.cy0, exp_active.cy0);
                    check("apply_cy1", cur.cy1, exp_active.cy1);
                    check("apply_cy2", cur.cy2, exp_active.cy2);
`ifdef IIR_SEQ_FLUSH_EN
                    check("flush_on_apply", flush, 1);
`else
                    check("flush_on_apply", flush, 0);
`endif
                end else begin
                    if (cur !== exp_active) torn++;
                    if (flush) stray++;
                end
                prev_busy = bus.busy;
                prev_sce  = sample_ce;
            end
        end
    end

    initial begin
        bank_t b;
        int    t;

        tbl[0]  = mk_vec(4'd3,  32'h00A12345, 1, 0,
                         mk_bank(DefCx, DefCxs, 24'hA12345, DefCy1, DefCy2));
        tbl[1]  = mk_vec(4'd0,  32'h89ABCDEF, 0, 0, '0);
        tbl[2]  = mk_vec(4'd1,  32'h00000012, 1, 0,
                         mk_bank(40'h1289ABCDEF, DefCxs, 24'hA12345, DefCy1, DefCy2));
        tbl[3]  = mk_vec(4'd2,  32'hFF332211, 1, 0,
                         mk_bank(40'h1289ABCDEF, 24'h332211, 24'hA12345, DefCy1, DefCy2));
        tbl[4]  = mk_vec(4'd4,  32'h12654321, 1, 0,
                         mk_bank(40'h1289ABCDEF, 24'h332211, 24'hA12345, 24'h654321, DefCy2));
        tbl[5]  = mk_vec(4'd5,  32'h00ABCDEF, 0, 0, '0);
        tbl[6]  = mk_vec(4'd5,  32'h55777777, 1, 0,
                         mk_bank(40'h1289ABCDEF, 24'h332211, 24'hA12345, 24'h654321, 24'h777777));
        tbl[7]  = mk_vec(4'd9,  32'hFFFFFFFF, 0, 1, '0);
        tbl[8]  = mk_vec(4'd0,  32'h00000001, 1, 1,
                         mk_bank(40'h1200000001, 24'h332211, 24'hA12345, 24'h654321, 24'h777777));
        tbl[9]  = mk_vec(4'd15, 32'h00000000, 0, 1, '0);
        tbl[10] = mk_vec(4'd1,  32'hFFFFFFAB, 1, 1,
                         mk_bank(40'hAB00000001, 24'h332211, 24'hA12345, 24'h654321, 24'h777777));

        exp_active = mk_bank(DefCx, DefCxs, DefCy0, DefCy1, DefCy2);
        reset      = 1'b1;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.commit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_ce", ce, 0);
        check("rst_sample_ce", sample_ce, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_err", bus.wr_err, 0);
        check("rst_flush", flush, 0);
        check("rst_cx", cx, DefCx);
        check("rst_cxs", {cx2, cx1, cx0}, DefCxs);
        check("rst_cy0", cy0, DefCy0);

        // Divider/phase: ce every CeDiv edges, sample_ce every second ce.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("ce_at_%0d", k), ce, (k % 4) == 0);
            check($sformatf("sample_ce_at_%0d", k), sample_ce, (k % 8) == 0);
        end

        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            write_reg(tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_wr_err", i), bus.wr_err, tbl[i].exp_err);
            if (tbl[i].commit) begin
                sb.push_back(tbl[i].exp);
                commit_pulse();
                wait_applied();
            end
        end

        // Reset while a commit of a new cy1 is pending.
        write_reg(4'd4, 32'h00ABCDEF);
        commit_pulse();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        exp_active = mk_bank(DefCx, DefCxs, DefCy0, DefCy1, DefCy2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_wr_err", bus.wr_err, 0);
        check("mid_rst_cy1", cy1, DefCy1);
        check("mid_rst_cx", cx, DefCx);
        @(posedge clk); #1;
        sb.push_back(mk_bank(DefCx, DefCxs, DefCy0, DefCy1, DefCy2));
        commit_pulse();
        wait_applied();

        // Write while busy is dropped; the older shadow cy2 is what gets applied.
        write_reg(4'd5, 32'h00111111);
        b = mk_bank(DefCx, DefCxs, DefCy0, DefCy1, 24'h111111);
        sb.push_back(b);
        commit_pulse();
        write_reg(4'd5, 32'h00999999);
        check("busy_write_wr_err", bus.wr_err, 1);
        wait_applied();
        sb.push_back(b);
        commit_pulse();
        wait_applied();
        check("wr_err_sticky", bus.wr_err, 1);

        // Write + commit in the same cycle, coincident with sample_ce, then a redundant commit.
        t = 0;
        while (!sample_ce && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("found_sample_ce", sample_ce, 1);
        bus.wr     = 1'b1;
        bus.addr   = 4'd3;
        bus.wdata  = 32'h00BEEF01;
        bus.commit = 1'b1;
        sb.push_back(mk_bank(DefCx, DefCxs, 24'hBEEF01, DefCy1, 24'h111111));
        @(posedge clk); #1;
        bus.wr     = 1'b0;
        bus.commit = 1'b0;
        check("coincident_busy", bus.busy, 1);
        check("coincident_cy0_held", cy0, DefCy0);
        commit_pulse();
        wait_applied();
        repeat (20) @(posedge clk);
        #1;
        check("no_extra_pending", bus.busy, 0);

        check("active_stable_between_applies", torn, 0);
        check("no_stray_flush", stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
